// File: rtl/subtrator_serial_pkg.sv
// rtl/subtrator_serial_pkg.sv - shared FSM state type and step helper for the serial subtractor
package subtrator_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/subtrator_digito.sv
// rtl/subtrator_digito.sv - DIGIT-bit ripple of one-bit full-subtractor cells
module subtrator_digito
  import subtrator_serial_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] chain;

  assign chain[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]       = a[i] ^ b[i] ^ chain[i];
    assign chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
  end

  assign bout = chain[DIGIT];

endmodule

// File: rtl/subtrator_serial.sv
// rtl/subtrator_serial.sv - multi-cycle N-bit subtractor, DIGIT bits per clock, LSB first
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             BorrowOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CW    = $clog2(STEPS + 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("subtrator_serial: DIGIT must divide WIDTH and WIDTH must be at least 2");
  end

  state_t           state;
  logic [CW-1:0]    step;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] a_next;
  logic             borrow_ff;
  logic             a_msb;
  logic             b_msb;
  logic [DIGIT-1:0] dig_d;
  logic             dig_bout;

  subtrator_digito #(.DIGIT(DIGIT)) u_digito (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .bin  (borrow_ff),
    .d    (dig_d),
    .bout (dig_bout)
  );

  // The minuend register doubles as the result register: each digit consumed
  // from the bottom frees room at the top for the freshly computed digit.
  if (STEPS == 1) begin : g_single
    assign a_next = dig_d;
  end else begin : g_multi
    assign a_next = {dig_d, a_sh[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      borrow_ff <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      D         <= '0;
      BorrowOut <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh      <= A;
            b_sh      <= B;
            borrow_ff <= BorrowIn;
            a_msb     <= A[WIDTH-1];
            b_msb     <= B[WIDTH-1];
            step      <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh      <= a_next;
          b_sh      <= b_sh >> DIGIT;
          borrow_ff <= dig_bout;
          step      <= step + CW'(1);
          if (step == CW'(STEPS - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            D         <= a_next;
            BorrowOut <= dig_bout;
            Overflow  <= (a_msb ^ b_msb) & (a_next[WIDTH-1] ^ a_msb);
            Zero      <= (a_next == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
